// File: rtl/dc_seq_pkg.sv
// Shared types and constants for the DC sequencer output path (slew limiter).
package dc_seq_pkg;

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_PRESCALE_W = 16;

  localparam int DATA_MAX = 32767;
  localparam int DATA_MIN = -32768;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_UP = 2'd1,
    RAMP_DN = 2'd2
  } slew_state_e;

endpackage

// File: rtl/dc_slew_limiter_tick_divider.sv
// Ramp tick prescaler: one tick every prescale+1 running, un-held clocks.
module dc_slew_limiter_tick_divider #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  run,
  input  logic                  hold,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick_c
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // >= so a prescale lowered below the running count ticks at the next compare
  assign tick_c = run && !hold && (cnt_q >= prescale);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run && !hold) begin
      cnt_d = tick_c ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dc_slew_limiter.sv
// Slew-rate limiter between the DC sequencer and the DAC output register.
// Optional Done pulse on tick-completed ramps: DC_SLEW_DONE_PULSE_EN.
module dc_slew_limiter
  import dc_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_W-1:0]     Target,
  input  logic [DATA_W-1:0]     Step,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Enable,
  input  logic                  Hold,
  output logic [DATA_W-1:0]     Dout,
  output logic                  Busy,
`ifdef DC_SLEW_DONE_PULSE_EN
  output logic                  Done,
`endif
  output logic                  AtTarget
);

  localparam int unsigned DW1 = DATA_W + 1;
  localparam int unsigned SW  = DATA_W + 2;
  localparam logic signed [SW-1:0] SAT_MAX = $signed({3'b000, {(DATA_W-1){1'b1}}});
  localparam logic signed [SW-1:0] SAT_MIN = $signed({3'b111, {(DATA_W-1){1'b0}}});

  slew_state_e           state_q, state_d;
  logic [DATA_W-1:0]     tgt_q, dout_q, dout_d;
  logic                  busy_q, busy_d;
  logic                  at_tgt_q, at_tgt_d;

  logic                  bypass_c, tick_c, cnt_clr_c, ramping_c, within_c;
  logic signed [DW1-1:0] diff_c;
  logic [DW1-1:0]        diff_mag_c;
  logic signed [SW-1:0]  dout_ext_c, step_ext_c, sum_c;
  logic [DATA_W-1:0]     sum_sat_c;

  assign bypass_c  = !Enable || (Step == '0);
  assign ramping_c = (state_q == RAMP_UP) || (state_q == RAMP_DN);

  // Full-width difference; its sign picks the ramp direction at each tick
  assign diff_c     = $signed({tgt_q[DATA_W-1], tgt_q}) - $signed({dout_q[DATA_W-1], dout_q});
  assign diff_mag_c = diff_c[DW1-1] ? $unsigned(DW1'(-diff_c)) : $unsigned(diff_c);
  assign within_c   = (diff_mag_c <= {1'b0, Step});

  // Saturating Dout +/- Step, wide enough that the guard itself never wraps
  always_comb begin
    dout_ext_c = $signed({{2{dout_q[DATA_W-1]}}, dout_q});
    step_ext_c = $signed({2'b00, Step});
    sum_c      = diff_c[DW1-1] ? (dout_ext_c - step_ext_c) : (dout_ext_c + step_ext_c);
    if (sum_c > SAT_MAX)      sum_sat_c = SAT_MAX[DATA_W-1:0];
    else if (sum_c < SAT_MIN) sum_sat_c = SAT_MIN[DATA_W-1:0];
    else                      sum_sat_c = sum_c[DATA_W-1:0];
  end

  dc_slew_limiter_tick_divider #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_div (
    .clk      (Clk),
    .rst_n    (Reset),
    .clr      (cnt_clr_c),
    .run      (ramping_c),
    .hold     (Hold),
    .prescale (Prescale),
    .tick_c   (tick_c)
  );

  // Next state / next output
  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    cnt_clr_c = 1'b0;
    if (bypass_c) begin
      state_d   = IDLE;
      dout_d    = tgt_q;
      cnt_clr_c = 1'b1;
    end else if (!Hold) begin
      case (state_q)
        IDLE: begin
          cnt_clr_c = 1'b1;
          if (diff_c != '0) state_d = diff_c[DW1-1] ? RAMP_DN : RAMP_UP;
        end
        RAMP_UP, RAMP_DN: begin
          if (tick_c) begin
            if (within_c) begin
              dout_d    = tgt_q;
              state_d   = IDLE;
              cnt_clr_c = 1'b1;
            end else begin
              dout_d  = sum_sat_c;
              state_d = diff_c[DW1-1] ? RAMP_DN : RAMP_UP;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_clr_c = 1'b1;
        end
      endcase
    end
    busy_d   = (state_d != IDLE);
    at_tgt_d = (dout_d == Target);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      at_tgt_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      tgt_q    <= Target;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      at_tgt_q <= at_tgt_d;
    end
  end

  assign Dout     = dout_q;
  assign Busy     = busy_q;
  assign AtTarget = at_tgt_q;

`ifdef DC_SLEW_DONE_PULSE_EN
  logic done_q, done_d;

  // Only a tick-driven landing counts; bypass and reset never pulse
  always_comb begin
    done_d = !bypass_c && !Hold && tick_c && (state_d == IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) done_q <= 1'b0;
    else        done_q <= done_d;
  end

  assign Done = done_q;
`endif

endmodule

// File: tb/tb_dc_slew_limiter.sv
// Directed self-checking bench for dc_slew_limiter (Done checked when DC_SLEW_DONE_PULSE_EN is set).
module tb_dc_slew_limiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Target = '0;
  logic [15:0] Step = '0;
  logic [15:0] Prescale = '0;
  logic        Enable = 1'b0;
  logic        Hold = 1'b0;
  logic [15:0] Dout;
  logic        Busy;
  logic        AtTarget;
`ifdef DC_SLEW_DONE_PULSE_EN
  logic        Done;
  int          done_cnt = 0;
`endif

  int n_checks = 0;
  int n_err    = 0;

  dc_slew_limiter dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Target   (Target),
    .Step     (Step),
    .Prescale (Prescale),
    .Enable   (Enable),
    .Hold     (Hold),
    .Dout     (Dout),
    .Busy     (Busy),
`ifdef DC_SLEW_DONE_PULSE_EN
    .Done     (Done),
`endif
    .AtTarget (AtTarget)
  );

  always #5 Clk = ~Clk;

`ifdef DC_SLEW_DONE_PULSE_EN
  always @(posedge Clk) if (Done === 1'b1) done_cnt <= done_cnt + 1;
`endif

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sdout();
    return int'($signed(Dout));
  endfunction

  task automatic chk_state(input string tag, input int dout, input int busy, input int att);
    chk({tag, ".dout"}, sdout(), dout);
    chk({tag, ".busy"}, int'(Busy), busy);
    chk({tag, ".at"}, int'(AtTarget), att);
  endtask

  task automatic go_bypass(input int lvl);
    Enable = 1'b0;
    Target = 16'(lvl);
    tick();
    tick();
  endtask

  initial begin
    int v;
    // reset state
    #2 Reset = 1'b0;
    #1 chk_state("reset_async", 0, 0, 1);
    tick();
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_state("reset_hold", 0, 0, 1);
    end

    // Step=100, Prescale=0, 0 -> 1000
    Enable = 1'b1; Step = 16'd100; Prescale = 16'd0; Target = 16'd1000;
    tick();
    chk_state("up_lat1", 0, 0, 0);
    tick();
    chk_state("up_start", 0, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("up_dout", sdout(), 100 * i);
      chk("up_busy", int'(Busy), (i < 10) ? 1 : 0);
      chk("up_at", int'(AtTarget), (i == 10) ? 1 : 0);
    end

    // Step=300, Prescale=3, 0 -> -1000, last step clipped
    go_bypass(0);
    chk_state("byp0", 0, 0, 1);
    Enable = 1'b1; Step = 16'd300; Prescale = 16'd3; Target = 16'(-1000);
    tick();
    tick();
    chk_state("dn_start", 0, 1, 0);
    v = 0;
    for (int j = 1; j <= 4; j++) begin
      repeat (3) tick();
      chk("dn_wait", sdout(), v);
      tick();
      v = (j < 4) ? -300 * j : -1000;
      chk("dn_tick", sdout(), v);
    end
    chk_state("dn_end", -1000, 0, 1);

    // reversal mid-ramp
    go_bypass(0);
    Enable = 1'b1; Step = 16'd100; Prescale = 16'd3; Target = 16'd1000;
    tick();
    tick();
    chk("rev_busy", int'(Busy), 1);
    for (int k = 1; k <= 5; k++) begin
      repeat (4) tick();
      chk("rev_up", sdout(), 100 * k);
    end
    Target = 16'd200;
    repeat (4) tick();
    chk_state("rev_400", 400, 1, 0);
    repeat (4) tick();
    chk_state("rev_300", 300, 1, 0);
    repeat (4) tick();
    chk_state("rev_200", 200, 0, 1);

    // full-scale single tick, no wrap
    go_bypass(-32768);
    chk_state("min_lvl", -32768, 0, 1);
    Enable = 1'b1; Step = 16'hFFFF; Prescale = 16'd0; Target = 16'd32767;
    tick();
    tick();
    chk_state("fs_start", -32768, 1, 0);
    tick();
    chk_state("fs_land", 32767, 0, 1);

    // Hold freezes mid-ramp, then resumes
    go_bypass(0);
    Enable = 1'b1; Step = 16'd100; Prescale = 16'd1; Target = 16'd1000;
    repeat (6) tick();
    chk_state("hold_pre", 200, 1, 0);
    Hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_dout", sdout(), 200);
      chk("hold_busy", int'(Busy), 1);
    end
    Hold = 1'b0;
    tick();
    chk("hold_rel1", sdout(), 200);
    tick();
    chk("hold_rel2", sdout(), 300);
    // bypass overrides Hold
    Hold = 1'b1; Enable = 1'b0;
    tick();
    chk_state("byp_hold", 1000, 0, 1);
    Hold = 1'b0;

    // bypass: two-cycle latency from Target
    Target = 16'd1234;
    tick();
    chk("byp_lat1", sdout(), 1000);
    tick();
    chk_state("byp_lat2", 1234, 0, 1);
    Target = 16'(-5);
    tick();
    tick();
    chk_state("byp_neg", -5, 0, 1);

    // Step=0 bypasses even with Enable=1
    Enable = 1'b1; Step = 16'd0; Target = 16'd77;
    tick();
    chk("step0_lat1", sdout(), -5);
    tick();
    chk_state("step0", 77, 0, 1);

    // reset asserted mid-ramp
    Step = 16'd10; Prescale = 16'd0; Target = 16'd1000;
    repeat (5) tick();
    chk_state("pre_rst", 107, 1, 0);
    #2 Reset = 1'b0;
    #1 chk_state("mid_rst", 0, 0, 1);
    Target = 16'd0;
    tick();
    Reset = 1'b1;
    tick();
    chk_state("post_rst", 0, 0, 1);

`ifdef DC_SLEW_DONE_PULSE_EN
    chk("done_count", done_cnt, 4);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
